cmd_framer: RTL and testbench

Host-side command framer for the FPGA control link: the transmit end of the 6-byte command packet protocol that the board controller consumes. Accepts one command (address, opcode, 32-bit payload) on a valid/ready port, serialises it byte-by-byte into the UART transmitter using a start/busy handshake and, for read-accumulator commands (opcode 2), collects the 4-byte response from the UART receiver. Sits between the host command source and the UART tx/rx pair.

---
 rtl/cmd_framer.sv | 174 +++++++++++++++++
 tb/tb_cmd_framer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_framer.sv
// Transmit end of the 6-byte command link: serialises addr, op, data[31:0] into the
// UART tx and, for the response opcode, gathers a 4-byte reply from the UART rx.
//
// state     | meaning
// S_IDLE    | waiting for a command, cmd_ready high
// S_SEND    | waiting for tx idle, then issue tx_start with current byte
// S_WAIT_HI | waiting for tx_busy to rise (timeout guarded)
// S_WAIT_LO | waiting for tx_busy to fall, then advance to next byte
// S_GAP     | inter-byte idle cycles
// S_RESP    | collecting 4 response bytes (timeout guarded between bytes)
module cmd_framer #(
  parameter int GAP     = 0,
  parameter int TIMEOUT = 50000,
  parameter int RESP_OP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [31:0] resp_data,
  output logic        resp_valid,
  output logic        done,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO, S_GAP, S_RESP
  } state_t;

  localparam logic [15:0] TO_CNT   = 16'(TIMEOUT);
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);
  localparam logic [7:0]  RESP_OP8 = 8'(RESP_OP);

  state_t      state, state_n;
  logic [47:0] sreg, sreg_n;
  logic [7:0]  op_q, op_n;
  logic [2:0]  idx, idx_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0]  rcnt, rcnt_n;
  logic [23:0] acc, acc_n;
  logic [7:0]  tx_data_n;
  logic [31:0] resp_data_n;
  logic        tx_start_n, resp_valid_n, done_n, err_n;

  assign cmd_ready = (state == S_IDLE);

  always_comb begin
    state_n      = state;
    sreg_n       = sreg;
    op_n         = op_q;
    idx_n        = idx;
    cnt_n        = cnt;
    rcnt_n       = rcnt;
    acc_n        = acc;
    tx_data_n    = tx_data;
    resp_data_n  = resp_data;
    tx_start_n   = 1'b0;
    resp_valid_n = 1'b0;
    done_n       = 1'b0;
    err_n        = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          sreg_n  = {cmd_addr, cmd_op, cmd_data};
          op_n    = cmd_op;
          idx_n   = 3'd0;
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_data_n  = sreg[47:40];
          tx_start_n = 1'b1;
          cnt_n      = 16'd0;
          state_n    = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (tx_busy) begin
          state_n = S_WAIT_LO;
        end else if (cnt == TO_CNT) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx == 3'd5) begin
            if (op_q == RESP_OP8) begin
              cnt_n   = 16'd0;
              rcnt_n  = 2'd0;
              state_n = S_RESP;
            end else begin
              done_n  = 1'b1;
              state_n = S_IDLE;
            end
          end else begin
            idx_n   = idx + 3'd1;
            sreg_n  = {sreg[39:0], 8'h00};
            cnt_n   = 16'd0;
            state_n = (GAP == 0) ? S_SEND : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) state_n = S_SEND;
        else cnt_n = cnt + 16'd1;
      end
      S_RESP: begin
        // a byte arriving on the expiry cycle still counts
        if (rx_valid) begin
          acc_n  = {acc[15:0], rx_data};
          cnt_n  = 16'd0;
          rcnt_n = rcnt + 2'd1;
          if (rcnt == 2'd3) begin
            resp_data_n  = {acc, rx_data};
            resp_valid_n = 1'b1;
            done_n       = 1'b1;
            state_n      = S_IDLE;
          end
        end else if (cnt == TO_CNT) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      sreg        <= '0;
      op_q        <= '0;
      idx         <= '0;
      cnt         <= '0;
      rcnt        <= '0;
      acc         <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      resp_data   <= '0;
      resp_valid  <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      sreg        <= sreg_n;
      op_q        <= op_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      rcnt        <= rcnt_n;
      acc         <= acc_n;
      tx_data     <= tx_data_n;
      tx_start    <= tx_start_n;
      resp_data   <= resp_data_n;
      resp_valid  <= resp_valid_n;
      done        <= done_n;
      err_timeout <= err_n;
    end
  end

endmodule

// File: tb/tb_cmd_framer.sv
// Scoreboard bench for cmd_framer: stimulus pushes expected tx bytes, terminal
// events and responses; a negedge monitor pops and compares what the DUT presents.
module tb_cmd_framer;

  localparam int GAP  = 3;
  localparam int TO   = 20;
  localparam int BUSY = 10;
  // busy + gap + one cycle each for busy-rise detect, busy-fall detect and start register
  localparam int SPACING = BUSY + GAP + 3;
  localparam logic [2:0] EV_DONE = 3'b001, EV_RESP = 3'b011, EV_ERR = 3'b100;

  typedef struct { logic [7:0] b; bit first; } tx_exp_t;
  typedef struct { logic [2:0] code; bit chk_delay; } ev_exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_addr = '0, cmd_op = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ready, tx_start, tx_busy, resp_valid, done, err_timeout;
  logic [7:0]  tx_data;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [31:0] resp_data;

  cmd_framer #(.GAP(GAP), .TIMEOUT(TO), .RESP_OP(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_data(rx_data), .resp_data(resp_data),
    .resp_valid(resp_valid), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART tx model: busy for BUSY cycles after it samples tx_start
  int busy_cnt;
  bit uart_en = 1'b1, busy_force = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (tx_start && uart_en) busy_cnt <= BUSY;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = busy_force | (busy_cnt != 0);

  tx_exp_t     exp_tx[$];
  ev_exp_t     exp_ev[$];
  logic [31:0] exp_resp[$];
  logic [31:0] model_resp = '0;
  int n_cmp = 0, n_err = 0;
  int last_start = 0, err_ref = 0, exp_first_cyc = -1;
  bit ready_chk = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: output seen with nothing expected (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ready_chk) begin
        chk("cmd_ready_after_end", cmd_ready, 1);
        ready_chk = 1'b0;
      end
      if (tx_start) begin
        if (exp_tx.size() == 0) unexpected("tx_start");
        else begin
          tx_exp_t e;
          e = exp_tx.pop_front();
          chk("tx_byte", tx_data, e.b);
          if (!e.first) chk("tx_spacing", cyc - last_start, SPACING);
          else if (exp_first_cyc >= 0) begin
            chk("first_start_cycle", cyc, exp_first_cyc);
            exp_first_cyc = -1;
          end
        end
        last_start = cyc;
        err_ref    = cyc;
      end
      if (done || resp_valid || err_timeout) begin
        if (exp_ev.size() == 0) unexpected("terminal_event");
        else begin
          ev_exp_t v;
          v = exp_ev.pop_front();
          chk("event_code", {err_timeout, resp_valid, done}, v.code);
          if (err_timeout) begin
            chk("resp_data_kept", resp_data, model_resp);
            if (v.chk_delay) chk("timeout_delay", cyc - err_ref, TO + 1);
          end
        end
        if (resp_valid) begin
          if (exp_resp.size() == 0) unexpected("resp_valid");
          else begin
            model_resp = exp_resp.pop_front();
            chk("resp_data", resp_data, model_resp);
          end
        end
        ready_chk = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [7:0] a, input logic [7:0] op, input logic [31:0] d, input int nbytes);
    logic [47:0] p;
    tx_exp_t e;
    p = {a, op, d};
    for (int i = 0; i < nbytes; i++) begin
      e.b     = p[47 - 8*i -: 8];
      e.first = (i == 0);
      exp_tx.push_back(e);
    end
  endtask

  task automatic push_ev(input logic [2:0] code, input bit dly);
    ev_exp_t v;
    v.code      = code;
    v.chk_delay = dly;
    exp_ev.push_back(v);
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] op, input logic [31:0] d, input bit track);
    if (track) exp_first_cyc = cyc + 2;
    cmd_addr  = a;
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    err_ref  = cyc + 1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic wait_tx_left(input int left, input int maxc, input string nm);
    int n = 0;
    while (exp_tx.size() > left && n < maxc) begin tick(); n++; end
    if (exp_tx.size() > left) begin
      n_cmp++; n_err++;
      $display("FAIL %s: tx bytes still pending %0d, expected %0d", nm, exp_tx.size(), left);
    end
  endtask

  task automatic wait_drained(input int maxc, input string nm);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_ev.size() != 0) && n < maxc) begin tick(); n++; end
    if (exp_tx.size() != 0 || exp_ev.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: pending tx %0d events %0d, expected 0 0", nm, exp_tx.size(), exp_ev.size());
    end
    tick(); tick();
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_cmd_ready"}, cmd_ready, 1);
    chk({nm, "_tx_data"}, tx_data, 0);
    chk({nm, "_tx_start"}, tx_start, 0);
    chk({nm, "_resp_data"}, resp_data, 0);
    chk({nm, "_resp_valid"}, resp_valid, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err_timeout"}, err_timeout, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // op 0: six bytes, one done; stray cmd_valid and rx_valid mid-packet are ignored
    push_pkt(8'h12, 8'h00, 32'hDEADBEEF, 6);
    push_ev(EV_DONE, 1'b0);
    send_cmd(8'h12, 8'h00, 32'hDEADBEEF, 1'b1);
    repeat (5) tick();
    cmd_addr = 8'hFF; cmd_op = 8'h02; cmd_data = 32'h11111111; cmd_valid = 1'b1;
    repeat (3) tick();
    cmd_valid = 1'b0;
    rx_byte(8'h55);
    wait_drained(400, "op0_packet");

    // op 2 with full response
    push_pkt(8'h34, 8'h02, 32'h00000001, 6);
    send_cmd(8'h34, 8'h02, 32'h00000001, 1'b1);
    wait_tx_left(0, 400, "op2_tx");
    repeat (15) tick();
    exp_resp.push_back(32'h01020304);
    push_ev(EV_RESP, 1'b0);
    rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'h03); rx_byte(8'h04);
    wait_drained(100, "op2_resp");

    // tx_busy never rises: timeout after first byte, nothing further sent
    uart_en = 1'b0;
    push_pkt(8'h56, 8'h01, 32'h0, 1);
    push_ev(EV_ERR, 1'b1);
    send_cmd(8'h56, 8'h01, 32'h0, 1'b1);
    wait_drained(100, "tx_timeout");
    repeat (30) tick();
    uart_en = 1'b1;

    // op 2 with only two response bytes: timeout, resp_data retained
    push_pkt(8'h78, 8'h02, 32'hCAFEF00D, 6);
    send_cmd(8'h78, 8'h02, 32'hCAFEF00D, 1'b1);
    wait_tx_left(0, 400, "resp_to_tx");
    repeat (15) tick();
    push_ev(EV_ERR, 1'b1);
    rx_byte(8'hAA); rx_byte(8'hBB);
    wait_drained(100, "resp_timeout");

    // tx busy at acceptance for 5 cycles: first start waits for busy low
    busy_force = 1'b1;
    tick();
    push_pkt(8'h9A, 8'h03, 32'h11223344, 6);
    push_ev(EV_DONE, 1'b0);
    send_cmd(8'h9A, 8'h03, 32'h11223344, 1'b0);
    repeat (4) tick();
    exp_first_cyc = cyc + 1;
    busy_force = 1'b0;
    wait_drained(400, "busy_at_accept");

    // reset mid-packet, then a fresh command restarts at the address byte
    push_pkt(8'h21, 8'h00, 32'h01020304, 6);
    push_ev(EV_DONE, 1'b0);
    send_cmd(8'h21, 8'h00, 32'h01020304, 1'b1);
    wait_tx_left(3, 400, "pre_reset_tx");
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_tx.delete();
    exp_ev.delete();
    model_resp = '0;
    ready_chk  = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    push_pkt(8'h43, 8'h00, 32'hA5A55A5A, 6);
    push_ev(EV_DONE, 1'b0);
    send_cmd(8'h43, 8'h00, 32'hA5A55A5A, 1'b1);
    wait_drained(400, "after_reset");
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
